microcode_unit: RTL and testbench

Microcode sequencer that sits between the microcode ROM (uop buffer) and the issue stage. It drives a read address into an external uop buffer and receives one 72-bit ROM row per cycle. Each row holds two instruction slots, which the unit decodes and issues as a registered dual-issue bundle. Sequencing starts automatically at BOOT_ADDR after reset, can be re-entered with a start request, and ends on an END marker.

---
 rtl/microcode_unit.sv | 142 ++++++++++++++
 tb/tb_microcode_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/microcode_unit.sv
// Microcode sequencer: walks the uop buffer from BOOT_ADDR (or a start request),
// decodes two slots per row and issues them as a registered dual-issue bundle.
module microcode_unit #(
    parameter int UOP_BUF_SIZE           = 128,
    parameter int UOP_BUF_WIDTH          = 72,
    parameter int MAX_PREDICT_DEPTH_BITS = 2,
    parameter int BOOT_ADDR              = 0,
    localparam int AW = $clog2(UOP_BUF_SIZE),
    localparam int TW = MAX_PREDICT_DEPTH_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [AW-1:0]            uop_addr,
    input  logic [UOP_BUF_WIDTH-1:0] uop,
    input  logic                     start,
    input  logic [AW-1:0]            start_addr,
    input  logic                     out_ready,
    output logic                     out_valid0,
    output logic                     out_valid1,
    output logic [31:0]              out_instr0,
    output logic [31:0]              out_instr1,
    output logic [TW-1:0]            out_tag0,
    output logic [TW-1:0]            out_tag1,
    output logic                     out_spec0,
    output logic                     out_spec1,
    output logic                     busy,
    output logic                     done
);

    localparam int SW = 32 + TW + 2;

    typedef enum logic {RUN, IDLE} state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic          valid0_n, valid1_n, spec0_n, spec1_n, busy_n, done_n;
    logic [31:0]   instr0_n, instr1_n;
    logic [TW-1:0] tag0_n, tag1_n;

    logic [SW-1:0] slot0, slot1;
    logic [31:0]   s0_instr, s1_instr;
    logic [TW-1:0] s0_tag, s1_tag;
    logic          s0_spec, s1_spec, s0_valid, s1_valid;
    logic          s0_end, s1_end, end_hit;

    assign slot0    = uop[UOP_BUF_WIDTH-1 -: SW];
    assign slot1    = uop[SW-1:0];
    assign s0_instr = slot0[SW-1 -: 32];
    assign s1_instr = slot1[SW-1 -: 32];
    assign s0_tag   = slot0[TW+1:2];
    assign s1_tag   = slot1[TW+1:2];
    assign s0_spec  = slot0[1];
    assign s1_spec  = slot1[1];
    assign s0_valid = slot0[0];
    assign s1_valid = slot1[0];

    // An END in slot 0 also kills the younger slot 1 of the same row.
    assign s0_end   = s0_valid && (s0_instr == '0);
    assign s1_end   = s1_valid && (s1_instr == '0);
    assign end_hit  = s0_end || s1_end;

    assign uop_addr = pc;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        valid0_n = out_valid0;
        valid1_n = out_valid1;
        instr0_n = out_instr0;
        instr1_n = out_instr1;
        tag0_n   = out_tag0;
        tag1_n   = out_tag1;
        spec0_n  = out_spec0;
        spec1_n  = out_spec1;
        busy_n   = busy;
        done_n   = 1'b0;

        if (start) begin
            pc_n     = start_addr;
            state_n  = RUN;
            valid0_n = 1'b0;
            valid1_n = 1'b0;
            busy_n   = 1'b1;
        end else if (state == RUN) begin
            busy_n = 1'b1;
            if (out_ready) begin
                valid0_n = s0_valid && !s0_end;
                valid1_n = s1_valid && !s1_end && !s0_end;
                instr0_n = s0_instr;
                instr1_n = s1_instr;
                tag0_n   = s0_tag;
                tag1_n   = s1_tag;
                spec0_n  = s0_spec;
                spec1_n  = s1_spec;
                if (end_hit) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else if (pc == AW'(UOP_BUF_SIZE - 1)) begin
                    pc_n = '0;
                end else begin
                    pc_n = pc + 1'b1;
                end
            end
        end else begin
            valid0_n = 1'b0;
            valid1_n = 1'b0;
            busy_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            pc         <= AW'(BOOT_ADDR);
            out_valid0 <= 1'b0;
            out_valid1 <= 1'b0;
            out_instr0 <= '0;
            out_instr1 <= '0;
            out_tag0   <= '0;
            out_tag1   <= '0;
            out_spec0  <= 1'b0;
            out_spec1  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            out_valid0 <= valid0_n;
            out_valid1 <= valid1_n;
            out_instr0 <= instr0_n;
            out_instr1 <= instr1_n;
            out_tag0   <= tag0_n;
            out_tag1   <= tag1_n;
            out_spec0  <= spec0_n;
            out_spec1  <= spec1_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_microcode_unit.sv
// Directed bench for microcode_unit: a vector table for the main sequence plus
// hand-written wrap-around and asynchronous reset sequences.
module tb_microcode_unit;

    localparam logic [31:0] A = 32'h2527_0004;
    localparam logic [31:0] B = 32'h2527_0005;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  uop_addr;
    logic [71:0] uop;
    logic        start;
    logic [6:0]  start_addr;
    logic        out_ready;
    logic        out_valid0, out_valid1, out_spec0, out_spec1, busy, done;
    logic [31:0] out_instr0, out_instr1;
    logic [1:0]  out_tag0, out_tag1;

    logic [71:0] rom [128];
    assign uop = rom[uop_addr];

    always #5 clk = ~clk;

    microcode_unit #(
        .UOP_BUF_SIZE(128),
        .UOP_BUF_WIDTH(72),
        .MAX_PREDICT_DEPTH_BITS(2),
        .BOOT_ADDR(0)
    ) dut (
        .clk(clk), .reset(reset), .uop_addr(uop_addr), .uop(uop),
        .start(start), .start_addr(start_addr), .out_ready(out_ready),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_tag0(out_tag0), .out_tag1(out_tag1),
        .out_spec0(out_spec0), .out_spec1(out_spec1),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic        start;
        logic [6:0]  sa;
        logic        rdy;
        logic [6:0]  addr;
        logic        v0, v1, ci0;
        logic [31:0] i0;
        logic [1:0]  t0;
        logic        s0, ci1;
        logic [31:0] i1;
        logic        busy, done;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [13];

    function automatic logic [35:0] mk(input logic [31:0] instr, input logic [1:0] tag,
                                       input logic spec, input logic valid);
        return {instr, tag, spec, valid};
    endfunction

    function automatic vec_t mv(input logic st, input logic [6:0] sa, input logic rdy,
                                input logic [6:0] addr, input logic v0, input logic v1,
                                input logic ci0, input logic [31:0] i0, input logic [1:0] t0,
                                input logic s0, input logic ci1, input logic [31:0] i1,
                                input logic bsy, input logic dn);
        vec_t v;
        v.start = st; v.sa = sa; v.rdy = rdy; v.addr = addr; v.v0 = v0; v.v1 = v1;
        v.ci0 = ci0; v.i0 = i0; v.t0 = t0; v.s0 = s0; v.ci1 = ci1; v.i1 = i1;
        v.busy = bsy; v.done = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0]   = {mk(A, 2'd2, 1'b1, 1'b1), mk(B, 2'd2, 1'b1, 1'b1)};
        rom[1]   = {mk(A, 2'd2, 1'b1, 1'b1), mk(B, 2'd2, 1'b1, 1'b1)};
        rom[2]   = {mk(A, 2'd2, 1'b1, 1'b1), mk(32'h0, 2'd2, 1'b1, 1'b1)};
        rom[5]   = {mk(32'h55, 2'd1, 1'b0, 1'b1), mk(32'hdead, 2'd0, 1'b0, 1'b0)};
        rom[6]   = {mk(32'h66, 2'd1, 1'b1, 1'b0), mk(32'h11, 2'd0, 1'b0, 1'b1)};
        rom[7]   = {mk(32'h0, 2'd0, 1'b0, 1'b1), mk(32'h99, 2'd0, 1'b0, 1'b1)};
        rom[127] = {mk(32'h127, 2'd3, 1'b0, 1'b1), mk(32'h128, 2'd1, 1'b1, 1'b1)};

        //               st sa   rdy addr v0 v1 ci0 i0      t0 s0 ci1 i1      busy done
        vecs[0]  = mv(0, 0,   1, 1,   1, 1, 1, A,      2, 1, 1, B,      1, 0);
        vecs[1]  = mv(0, 0,   1, 2,   1, 1, 1, A,      2, 1, 1, B,      1, 0);
        vecs[2]  = mv(0, 0,   1, 2,   1, 0, 1, A,      2, 1, 0, 0,      0, 1);
        vecs[3]  = mv(0, 0,   1, 2,   0, 0, 1, A,      2, 1, 0, 0,      0, 0);
        vecs[4]  = mv(1, 5,   1, 5,   0, 0, 0, 0,      0, 0, 0, 0,      1, 0);
        vecs[5]  = mv(0, 0,   1, 6,   1, 0, 1, 32'h55, 1, 0, 0, 0,      1, 0);
        vecs[6]  = mv(0, 0,   0, 6,   1, 0, 1, 32'h55, 1, 0, 0, 0,      1, 0);
        vecs[7]  = mv(0, 0,   0, 6,   1, 0, 1, 32'h55, 1, 0, 0, 0,      1, 0);
        vecs[8]  = mv(0, 0,   0, 6,   1, 0, 1, 32'h55, 1, 0, 0, 0,      1, 0);
        vecs[9]  = mv(0, 0,   1, 7,   0, 1, 0, 0,      0, 0, 1, 32'h11, 1, 0);
        vecs[10] = mv(0, 0,   1, 7,   0, 0, 0, 0,      0, 0, 0, 0,      0, 1);
        vecs[11] = mv(1, 127, 0, 127, 0, 0, 0, 0,      0, 0, 0, 0,      1, 0);
        vecs[12] = mv(0, 0,   1, 0,   1, 1, 1, 32'h127, 3, 0, 1, 32'h128, 1, 0);

        reset = 1'b0; start = 1'b0; start_addr = '0; out_ready = 1'b1;
        #12;
        chk("rst_addr",   32'(uop_addr), 32'd0);
        chk("rst_valid",  {30'd0, out_valid0, out_valid1}, 32'd0);
        chk("rst_instr0", out_instr0, 32'd0);
        chk("rst_instr1", out_instr1, 32'd0);
        chk("rst_tagspec", {26'd0, out_tag0, out_tag1, out_spec0, out_spec1}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        #3;
        for (int i = 0; i < 13; i++) begin
            start = vecs[i].start; start_addr = vecs[i].sa; out_ready = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_addr", i),   32'(uop_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_valid0", i), 32'(out_valid0), 32'(vecs[i].v0));
            chk($sformatf("v%0d_valid1", i), 32'(out_valid1), 32'(vecs[i].v1));
            chk($sformatf("v%0d_busy", i),   32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_done", i),   32'(done), 32'(vecs[i].done));
            if (vecs[i].ci0) begin
                chk($sformatf("v%0d_instr0", i), out_instr0, vecs[i].i0);
                chk($sformatf("v%0d_tag0", i),   32'(out_tag0), 32'(vecs[i].t0));
                chk($sformatf("v%0d_spec0", i),  32'(out_spec0), 32'(vecs[i].s0));
            end
            if (vecs[i].ci1)
                chk($sformatf("v%0d_instr1", i), out_instr1, vecs[i].i1);
        end
        start = 1'b0; out_ready = 1'b1;

        // Wrap: row 0 now ends the program after row 127.
        rom[0] = {mk(32'h77, 2'd0, 1'b0, 1'b1), mk(32'h0, 2'd0, 1'b0, 1'b1)};
        step();
        chk("wrap_addr",   32'(uop_addr), 32'd0);
        chk("wrap_valid",  {30'd0, out_valid0, out_valid1}, 32'b10);
        chk("wrap_instr0", out_instr0, 32'h77);
        chk("wrap_done",   32'(done), 32'd1);
        chk("wrap_busy",   32'(busy), 32'd0);
        step();
        chk("wrap_done_pulse", 32'(done), 32'd0);

        // Asynchronous reset while running at row 1.
        rom[0] = {mk(A, 2'd2, 1'b1, 1'b1), mk(B, 2'd2, 1'b1, 1'b1)};
        start = 1'b1; start_addr = 7'd0;
        step();
        start = 1'b0;
        chk("rs_start_addr", 32'(uop_addr), 32'd0);
        chk("rs_start_busy", 32'(busy), 32'd1);
        step();
        chk("rs_run_addr",   32'(uop_addr), 32'd1);
        chk("rs_run_instr0", out_instr0, A);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_mid_addr",  32'(uop_addr), 32'd0);
        chk("rs_mid_valid", {30'd0, out_valid0, out_valid1}, 32'd0);
        chk("rs_mid_instr", out_instr0 | out_instr1, 32'd0);
        chk("rs_mid_busy",  32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rs_replay_addr",  32'(uop_addr), 32'd1);
        chk("rs_replay_valid", {30'd0, out_valid0, out_valid1}, 32'b11);
        chk("rs_replay_instr0", out_instr0, A);
        chk("rs_replay_instr1", out_instr1, B);
        chk("rs_replay_busy",  32'(busy), 32'd1);
        step();
        chk("rs_replay2_addr", 32'(uop_addr), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
